// File: rtl/req_aging_unit_if.sv
// req_aging_unit_if
//   Bundles the request-conditioning signals between the upstream requesters
//   and the fair priority arbiter on one side and req_aging_unit on the other.
//   master : the environment (requesters + arbiter). It drives the strobes,
//            base priorities and the registered grant, and observes
//            request/priorities/pending/starve.
//   slave  : req_aging_unit.
//   Field i of base_priority/priorities sits at [(i+1)*PW-1 : i*PW].
interface req_aging_unit_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int PRIORITY_WIDTH = 2
);
  logic [NUM_REQUESTERS-1:0]                req_strobe;
  logic [NUM_REQUESTERS*PRIORITY_WIDTH-1:0] base_priority;
  logic [NUM_REQUESTERS-1:0]                grant;
  logic [NUM_REQUESTERS-1:0]                request;
  logic [NUM_REQUESTERS*PRIORITY_WIDTH-1:0] priorities;
  logic [NUM_REQUESTERS-1:0]                pending;
  logic [NUM_REQUESTERS-1:0]                starve;

  modport master (
    output req_strobe, base_priority, grant,
    input  request, priorities, pending, starve
  );

  modport slave (
    input  req_strobe, base_priority, grant,
    output request, priorities, pending, starve
  );
endinterface

// File: rtl/req_aging_unit.sv
// req_aging_unit
//   Request conditioning ahead of the fair priority arbiter. Single-cycle
//   request strobes are latched into sticky pending bits. Each waiting
//   requester ages, and every AGE_THRESHOLD un-granted cycles its priority is
//   boosted by one step, saturating at PMAX. The arbiter's registered grant
//   retires the pending request and clears the age and boost.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : req_aging_unit_if.slave
//     req_strobe    in  one-cycle pulse per requester
//     base_priority in  static priority per requester (packed fields)
//     grant         in  one-hot registered grant from the arbiter
//     request       out pending & ~grant, to the arbiter
//     priorities    out min(base + boost, PMAX) per requester
//     pending       out raw sticky pending state
//     starve        out starved at max priority (0 unless enabled)
//
// Optional feature macro: REQ_AGING_STARVE_EN
//   Defined: a registered starve flag per requester is built.
//   Undefined: starve is tied low and no starve flops exist.

// One requester's pending/age/boost state and its effective priority.
module req_aging_lane #(
  parameter int PRIORITY_WIDTH = 2,
  parameter int AGE_THRESHOLD  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      strobe,
  input  logic                      grant,
  input  logic [PRIORITY_WIDTH-1:0] base_prio,
  output logic                      request,
  output logic [PRIORITY_WIDTH-1:0] eff_prio,
  output logic                      pending,
  output logic                      starve
);
  localparam int AW = $clog2(AGE_THRESHOLD);
  localparam logic [AW-1:0]             AGE_WRAP = AW'(AGE_THRESHOLD - 1);
  localparam logic [PRIORITY_WIDTH-1:0] PMAX     = '1;

  logic                      pend_q, pend_d;
  logic [AW-1:0]             age_q, age_d;
  logic [PRIORITY_WIDTH-1:0] boost_q, boost_d;
  logic [PRIORITY_WIDTH:0]   prio_sum;

  // A grant in the same cycle as a strobe retires the old request and keeps
  // the new one pending; the age path below restarts it from zero.
  always_comb begin
    pend_d  = grant ? strobe : (pend_q | strobe);
    age_d   = age_q;
    boost_d = boost_q;
    if (grant || !pend_q) begin
      age_d   = '0;
      boost_d = '0;
    end else if (age_q == AGE_WRAP) begin
      age_d = '0;
      if (boost_q != PMAX) boost_d = boost_q + 1'b1;
    end else begin
      age_d = age_q + 1'b1;
    end
  end

  // One extra bit so the sum cannot wrap before saturating.
  always_comb begin
    prio_sum = {1'b0, base_prio} + {1'b0, boost_q};
    eff_prio = (prio_sum > {1'b0, PMAX}) ? PMAX : prio_sum[PRIORITY_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      age_q   <= '0;
      boost_q <= '0;
    end else begin
      pend_q  <= pend_d;
      age_q   <= age_d;
      boost_q <= boost_d;
    end
  end

  // The arbiter's grant is registered, so mask the request in the grant cycle
  // to stop a second grant being issued for the same request.
  assign request = pend_q & ~grant;
  assign pending = pend_q;

`ifdef REQ_AGING_STARVE_EN
  logic starve_q, starve_d;
  logic age_wrap;

  // A wrap while already at the top of the priority range means further
  // aging can no longer help this requester.
  always_comb begin
    age_wrap = pend_q & ~grant & (age_q == AGE_WRAP);
    starve_d = starve_q;
    if (grant) begin
      starve_d = 1'b0;
    end else if (age_wrap && ((boost_q == PMAX) || (eff_prio == PMAX))) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= 1'b0;
    else        starve_q <= starve_d;
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif
endmodule

module req_aging_unit #(
  parameter int NUM_REQUESTERS = 4,
  parameter int PRIORITY_WIDTH = 2,
  parameter int AGE_THRESHOLD  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  req_aging_unit_if.slave bus
);
  logic [NUM_REQUESTERS-1:0][PRIORITY_WIDTH-1:0] base_lane;
  logic [NUM_REQUESTERS-1:0][PRIORITY_WIDTH-1:0] prio_lane;
  logic [NUM_REQUESTERS-1:0]                     request_lane;
  logic [NUM_REQUESTERS-1:0]                     pending_lane;
  logic [NUM_REQUESTERS-1:0]                     starve_lane;

  assign base_lane = bus.base_priority;

  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_lane
    req_aging_lane #(
      .PRIORITY_WIDTH(PRIORITY_WIDTH),
      .AGE_THRESHOLD (AGE_THRESHOLD)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe   (bus.req_strobe[i]),
      .grant    (bus.grant[i]),
      .base_prio(base_lane[i]),
      .request  (request_lane[i]),
      .eff_prio (prio_lane[i]),
      .pending  (pending_lane[i]),
      .starve   (starve_lane[i])
    );
  end

  assign bus.request    = request_lane;
  assign bus.priorities = prio_lane;
  assign bus.pending    = pending_lane;
  assign bus.starve     = starve_lane;
endmodule

// File: tb/tb_req_aging_unit.sv
// Directed bench for req_aging_unit (4 requesters, 2-bit priority, age 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expectations are hand-derived constants.
module tb_req_aging_unit;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam int TH = 8;
`ifdef REQ_AGING_STARVE_EN
  localparam logic STV = 1'b1;
`else
  localparam logic STV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  req_aging_unit_if #(.NUM_REQUESTERS(N), .PRIORITY_WIDTH(PW)) bus ();

  req_aging_unit #(.NUM_REQUESTERS(N), .PRIORITY_WIDTH(PW), .AGE_THRESHOLD(TH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [PW-1:0] pf(input logic [N*PW-1:0] v, input int i);
    return v[i*PW +: PW];
  endfunction

  // Reference arbiter for the closed loop: highest priority, lowest index on ties.
  function automatic logic [N-1:0] pick(input logic [N-1:0] rq, input logic [N*PW-1:0] pr);
    int best;
    logic [PW-1:0] bp;
    logic [N-1:0] g;
    best = -1;
    bp   = '0;
    g    = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i] && (best < 0 || pr[i*PW +: PW] > bp)) begin
        best = i;
        bp   = pr[i*PW +: PW];
      end
    end
    if (best >= 0) g[best] = 1'b1;
    return g;
  endfunction

  localparam logic [N*PW-1:0] BASE = {2'd3, 2'd1, 2'd0, 2'd0};

  int gcnt [N];
  int gtot;

  initial begin
    rst_n             = 1'b0;
    bus.req_strobe    = '0;
    bus.grant         = '0;
    bus.base_priority = BASE;

    // Reset state
    smp();
    chk("rst_request", bus.request, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_prio", bus.priorities, BASE);
    chk("rst_starve", bus.starve, 0);
    rst_n = 1'b1;
    tick();
    tick();
    smp();
    chk("idle_request", bus.request, 0);
    chk("idle_pending", bus.pending, 0);
    chk("idle_prio", bus.priorities, BASE);
    chk("idle_starve", bus.starve, 0);

    // Strobe req 2, grant it two cycles later
    tick();
    bus.req_strobe = 4'b0100;
    smp();
    chk("t2_req_strobe_cyc", bus.request, 0);
    tick();
    bus.req_strobe = '0;
    smp();
    chk("t2_request_hi", bus.request[2], 1);
    chk("t2_prio2_a", pf(bus.priorities, 2), 1);
    tick();
    bus.grant = 4'b0100;
    smp();
    chk("t2_request_masked", bus.request[2], 0);
    chk("t2_pending_in_grant", bus.pending[2], 1);
    chk("t2_prio2_b", pf(bus.priorities, 2), 1);
    tick();
    bus.grant = '0;
    smp();
    chk("t2_pending_lo", bus.pending[2], 0);
    chk("t2_prio2_c", pf(bus.priorities, 2), 1);

    // Aging staircase on req 0 (base 0)
    tick();
    bus.req_strobe = 4'b0001;
    tick();
    bus.req_strobe = '0;
    for (int k = 0; k <= 40; k++) begin
      smp();
      case (k)
        7:  chk("t3_prio0_k7", pf(bus.priorities, 0), 0);
        8:  chk("t3_prio0_k8", pf(bus.priorities, 0), 1);
        15: chk("t3_prio0_k15", pf(bus.priorities, 0), 1);
        16: chk("t3_prio0_k16", pf(bus.priorities, 0), 2);
        24: chk("t3_prio0_k24", pf(bus.priorities, 0), 3);
        40: chk("t3_prio0_k40", pf(bus.priorities, 0), 3);
        default: ;
      endcase
      tick();
    end
    bus.grant = 4'b0001;
    tick();
    bus.grant = '0;
    smp();
    chk("t3_pending0_clr", bus.pending[0], 0);
    chk("t3_prio0_clr", pf(bus.priorities, 0), 0);
    chk("t3_starve_clr", bus.starve, 0);

    // Same-cycle strobe and grant on req 1 after 20 cycles waiting
    tick();
    bus.req_strobe = 4'b0010;
    tick();
    bus.req_strobe = '0;
    for (int k = 0; k < 20; k++) begin
      smp();
      if (k == 19) chk("t4_prio1_k19", pf(bus.priorities, 1), 2);
      tick();
    end
    bus.req_strobe = 4'b0010;
    bus.grant      = 4'b0010;
    smp();
    chk("t4_req1_masked", bus.request[1], 0);
    tick();
    bus.req_strobe = '0;
    bus.grant      = '0;
    for (int k = 0; k <= 8; k++) begin
      smp();
      if (k == 0) begin
        chk("t4_pending1_kept", bus.pending[1], 1);
        chk("t4_request1_hi", bus.request[1], 1);
        chk("t4_prio1_base", pf(bus.priorities, 1), 0);
      end
      if (k == 7) chk("t4_prio1_k7", pf(bus.priorities, 1), 0);
      if (k == 8) chk("t4_prio1_k8", pf(bus.priorities, 1), 1);
      tick();
    end
    bus.grant = 4'b0010;
    tick();
    bus.grant = '0;
    smp();
    chk("t4_pending1_clr", bus.pending[1], 0);

    // Starvation on req 3 (base 3)
    tick();
    bus.req_strobe = 4'b1000;
    tick();
    bus.req_strobe = '0;
    for (int k = 0; k <= 8; k++) begin
      smp();
      if (k == 0) chk("t5_prio3", pf(bus.priorities, 3), 3);
      if (k == 7) chk("t5_starve_k7", bus.starve, 0);
      if (k == 8) chk("t5_starve_k8", bus.starve, {28'd0, STV, 3'd0});
      tick();
    end
    bus.grant = 4'b1000;
    smp();
    chk("t5_starve_in_grant", bus.starve[3], STV);
    chk("t5_req3_masked", bus.request[3], 0);
    tick();
    bus.grant = '0;
    smp();
    chk("t5_starve_clr", bus.starve, 0);
    chk("t5_pending3_clr", bus.pending[3], 0);

    // Asynchronous reset mid-operation drops pending requests
    tick();
    bus.req_strobe = 4'b0011;
    tick();
    bus.req_strobe = '0;
    smp();
    chk("t6_pending_before", bus.pending, 4'b0011);
    rst_n = 1'b0;
    #1;
    chk("t6_pending_async", bus.pending, 0);
    chk("t6_request_async", bus.request, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    smp();
    chk("t6_pending_after", bus.pending, 0);

    // Closed loop with a registered reference arbiter
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    gtot = 0;
    tick();
    bus.req_strobe = 4'b1111;
    tick();
    bus.req_strobe = '0;
    for (int c = 0; c < 16; c++) begin
      logic [N-1:0] nxt;
      smp();
      for (int i = 0; i < N; i++) begin
        if (bus.grant[i]) begin
          gcnt[i]++;
          gtot++;
        end
      end
      nxt = pick(bus.request, bus.priorities);
      tick();
      bus.grant = nxt;
    end
    bus.grant = '0;
    smp();
    for (int i = 0; i < N; i++) chk($sformatf("t7_grants_req%0d", i), gcnt[i], 1);
    chk("t7_grant_total", gtot, 4);
    chk("t7_pending_drained", bus.pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
